div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//   Multi-cycle 32-bit integer divide sequencer for the EX stage. Accepts DIV/DIVU
//   operands from ex, runs a radix-2 restoring shift/subtract loop for 32 cycles,
//   and returns {remainder, quotient} for HI/LO write-back. Holds stallreq_o while
//   busy so the pipeline controller freezes IF/ID/EX until the result is ready.
// PARAMETERS
//   DW       32   operand width; the loop count equals DW
//   CNT_W     6   iteration counter width, clog2(DW)+1
// PORTS
//   clk           in   1     clock, rising edge
//   rst           in   1     asynchronous reset, active-low (rst==0 resets)
//   signed_div_i  in   1     1 = DIV (signed), 0 = DIVU
//   opdata1_i     in   32    dividend
//   opdata2_i     in   32    divisor
//   start_i       in   1     request; ex holds it high until ready_o is seen
//   annul_i       in   1     cancel (branch flush / exception); wins over start_i
//   result_o      out  64    {remainder[63:32], quotient[31:0]}
//   ready_o       out  1     result valid; high for exactly the DONE cycle(s)
//   stallreq_o    out  1     high whenever start_i=1 and ready_o=0
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, result_o=0, ready_o=0, all internal regs 0.
//   States: IDLE, BYZERO, RUN, DONE (encodings in shared defines).
//   IDLE:   start_i=1 & annul_i=0: divisor==0 -> BYZERO; else latch |dividend|,
//           |divisor| (two's-complement negate only when signed_div_i=1 and
//           MSB=1), latch sign flags, cnt=0 -> RUN. Otherwise stay; ready_o=0.
//   BYZERO: one cycle, result register=64'h0 -> DONE.
//   RUN:    each cycle: partial = {rem[30:0], dvd[31]} - dvs (33-bit subtract);
//           borrow -> shift in 0 and keep rem; else rem=partial, shift in 1;
//           cnt++. When cnt reaches 32: apply sign fix-up -> DONE.
//           annul_i=1 at any RUN cycle -> IDLE next edge, result discarded.
//   Sign fix-up (signed only): quotient negated if dividend and divisor signs
//           differ; remainder takes the dividend's sign. DIVU: no fix-up.
//   DONE:   result_o valid, ready_o=1. start_i=0 -> IDLE, ready_o=0 next
//           cycle; start_i still 1 -> stay DONE (result held stable).
//   Latency: start accepted to ready_o = 33 cycles (normal), 2 cycles
//           (divide-by-zero). No pipelining; one operation in flight.
//   stallreq_o is combinational: start_i & ~ready_o & ~annul_i.
//   Edge cases: 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000,
//           remainder 0 (wrap, no trap). Operands sampled only in IDLE; changes
//           during RUN are ignored. Async reset mid-RUN -> IDLE immediately,
//           ready_o=0, no partial result visible.
// STRUCTURE
//   defines.v: DivFree/DivByZero/DivOn/DivEnd state codes, DivStart/DivStop,
//     DivResultReady/DivResultNotReady, ZeroWord, DoubleRegBus width macro.
//   Sub-module: none required; the 33-bit subtract step may live inline.
//   Control FSM, counter and shift registers in one sequential block; sign
//     pre/post negation and stallreq_o in combinational blocks.
// TESTING
//   DIVU 100/7, start held -> ready_o at cycle 33, result_o={32'd2, 32'd14}.
//   DIV -100/7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2).
//   DIV 0x80000000/0xFFFFFFFF -> result_o={32'h0, 32'h80000000}, no hang.
//   Any op with divisor=0 -> ready_o after 2 cycles, result_o=64'h0.
//   annul_i pulse at RUN cycle 10 -> IDLE next edge, ready_o never asserts;
//     a following DIVU 9/3 returns {0, 3} with full 33-cycle latency.
//   rst low at RUN cycle 20 -> state IDLE, outputs 0 immediately (async).

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared constants for the EX-stage sequential divider.
// State codes and word constants used by div_seq.
package div_seq_pkg;

    localparam logic [1:0] DIV_FREE    = 2'd0;
    localparam logic [1:0] DIV_BY_ZERO = 2'd1;
    localparam logic [1:0] DIV_ON      = 2'd2;
    localparam logic [1:0] DIV_END     = 2'd3;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient}; stalls the pipeline while busy.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signed_div_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    input  logic            start_i,
    input  logic            annul_i,
    output logic [2*DW-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [2*DW-1:0] result_q, result_d;

    logic [DW:0]     partial;
    logic            q_bit;
    logic [DW-1:0]   rem_step;
    logic [DW-1:0]   quo_step;
    logic            neg_a;
    logic            neg_b;

    // Remainder keeps its full width so divisors above 2^(DW-1) stay exact.
    always_comb begin
        partial  = {rem_q, dvd_q[DW-1]} - {1'b0, dvs_q};
        q_bit    = ~partial[DW];
        rem_step = q_bit ? partial[DW-1:0] : {rem_q[DW-2:0], dvd_q[DW-1]};
        quo_step = {dvd_q[DW-2:0], q_bit};
        neg_a    = signed_div_i & opdata1_i[DW-1];
        neg_b    = signed_div_i & opdata2_i[DW-1];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        dvd_d     = neg_a ? -opdata1_i : opdata1_i;
                        dvs_d     = neg_b ? -opdata2_i : opdata2_i;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        state_d   = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    result_d = '0;
                    state_d  = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    rem_d = rem_step;
                    dvd_d = quo_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    // Last step: sign fix-up goes straight into the result.
                    if (cnt_q == CNT_W'(DW - 1)) begin
                        result_d = {neg_rem_q ? -rem_step : rem_step,
                                    neg_quo_q ? -quo_step : quo_step};
                        state_d  = DIV_END;
                    end
                end
            end
            default: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_d = DIV_FREE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        ready_o    = (state_q == DIV_END) ? DIV_RESULT_READY
                                          : DIV_RESULT_NOT_READY;
        result_o   = result_q;
        stallreq_o = start_i & ~ready_o & ~annul_i;
    end

endmodule

// File: tb/tb_div_seq.sv
// Randomized bench for div_seq against an arithmetic reference model.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int total;
    int bad;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input bit s,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        if (b == 32'h0) return 64'h0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    task automatic do_op(input bit s, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [63:0] exp;
        int          lat;
        int          exp_lat;
        exp     = ref_div(s, a, b);
        exp_lat = (b == 32'h0) ? 2 : 33;
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        chk("stall_busy", {63'h0, stallreq_o}, 64'h1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 3) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
            if (ready_o) break;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", result_o, exp);
        chk("stall_rdy", {63'h0, stallreq_o}, 64'h0);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            chk("hold_rdy", {63'h0, ready_o}, 64'h1);
            chk("hold_res", result_o, exp);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_drop", {63'h0, ready_o}, 64'h0);
    endtask

    initial begin
        int seen;
        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        chk("rst_rdy", {63'h0, ready_o}, 64'h0);
        chk("rst_res", result_o, 64'h0);
        chk("rst_stall", {63'h0, stallreq_o}, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        do_op(1'b0, 32'd100, 32'd7, 0);
        do_op(1'b1, -32'sd100, 32'd7, 2);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(1'b1, 32'd55, 32'd0, 1);
        do_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        do_op(1'b1, 32'd100, -32'sd7, 0);
        do_op(1'b0, 32'h0, 32'd5, 0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                default: ;
            endcase
            do_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2));
        end

        // Cancel mid-run: the aborted op must never report ready.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd9;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("stall_annul", {63'h0, stallreq_o}, 64'h0);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        seen    = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        chk("annul_rdy", 64'(seen), 64'h0);
        do_op(1'b0, 32'd9, 32'd3, 0);

        // Async reset in the middle of a run.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd12345;
        opdata2_i    = 32'd17;
        start_i      = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        chk("arst_rdy", {63'h0, ready_o}, 64'h0);
        chk("arst_res", result_o, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        chk("arst_idle", 64'(seen), 64'h0);
        do_op(1'b1, 32'd12345, -32'sd17, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
